// File: rtl/ultrasonic_meas_ctrl.sv
// Trigger/echo sequencer for an HC-SR04-class ranging sensor.
// Times the echo on a 1 us tick and converts it to cm with a running sub-counter.
module ultrasonic_meas_ctrl #(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned TRIG_US     = 10,
  parameter int unsigned TIMEOUT_US  = 38000,
  parameter int unsigned HOLDOFF_US  = 60000,
  parameter int unsigned CM_DIV_US   = 58
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        start,
  input  logic        auto_en,
  input  logic        echo,
  output logic        trig,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] echo_us,
  output logic [15:0] distance_cm
);

  localparam int unsigned Div = CLK_FREQ_HZ / 1000000;
  localparam int unsigned PW  = (Div > 1) ? $clog2(Div) : 1;

  typedef enum logic [2:0] {StIdle, StTrig, StWaitRise, StMeasure, StHoldoff} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          us_tick, to_expire;
  logic [19:0]   us_cnt_q, us_cnt_d, to_cnt_q, to_cnt_d;
  logic [15:0]   echo_cnt_q, echo_cnt_d, cm_sub_q, cm_sub_d, cm_cnt_q, cm_cnt_d;
  logic [15:0]   echo_inc, cm_sub_inc, cm_inc;
  logic          echo_meta_q, echo_sync_q, echo_dly_q, rise_q, fall_q;
  logic          trig_q, trig_d, done_q, done_d, timeout_q, timeout_d;
  logic [15:0]   echo_us_q, echo_us_d, distance_q, distance_d;
  logic          load_valid, load_to;

  // Two-flop synchronizer followed by a registered edge detector.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      echo_meta_q <= 1'b0;
      echo_sync_q <= 1'b0;
      echo_dly_q  <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      echo_meta_q <= echo;
      echo_sync_q <= echo_meta_q;
      echo_dly_q  <= echo_sync_q;
      rise_q      <= echo_sync_q & ~echo_dly_q;
      fall_q      <= ~echo_sync_q & echo_dly_q;
    end
  end

  assign us_tick   = (presc_q == PW'(Div - 1));
  assign to_expire = us_tick && (to_cnt_q == 20'(TIMEOUT_US - 1));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (start || auto_en) state_d = StTrig;
      StTrig:     if (us_tick && us_cnt_q == 20'(TRIG_US - 1)) state_d = StWaitRise;
      // Expiry beats a coincident rise so the timeout counter can never overrun.
      StWaitRise: begin
        if (to_expire)   state_d = StHoldoff;
        else if (rise_q) state_d = StMeasure;
      end
      StMeasure:  if (fall_q || to_expire) state_d = StHoldoff;
      StHoldoff:  if (us_tick && us_cnt_q == 20'(HOLDOFF_US - 1)) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    busy       = (state_q != StIdle);
    trig_d     = (state_d == StTrig);
    load_valid = (state_q == StMeasure) && fall_q;
    load_to    = to_expire && ((state_q == StWaitRise) || (state_q == StMeasure && !fall_q));
    done_d     = load_valid | load_to;
  end

  always_comb begin
    presc_d = (state_d != state_q || us_tick) ? '0 : presc_q + 1'b1;

    us_cnt_d = us_cnt_q;
    if (state_d != state_q) us_cnt_d = '0;
    else if (us_tick && (state_q == StTrig || state_q == StHoldoff)) us_cnt_d = us_cnt_q + 1'b1;

    to_cnt_d = to_cnt_q;
    if (state_q == StTrig) to_cnt_d = '0;
    else if (us_tick && (state_q == StWaitRise || state_q == StMeasure)) to_cnt_d = to_cnt_q + 1'b1;

    // Values including the current tick, so the fall cycle's microsecond is counted.
    echo_inc   = echo_cnt_q;
    cm_sub_inc = cm_sub_q;
    cm_inc     = cm_cnt_q;
    if (us_tick) begin
      if (echo_cnt_q != '1) echo_inc = echo_cnt_q + 1'b1;
      if (cm_sub_q == 16'(CM_DIV_US - 1)) begin
        cm_sub_inc = '0;
        if (cm_cnt_q != '1) cm_inc = cm_cnt_q + 1'b1;
      end else begin
        cm_sub_inc = cm_sub_q + 1'b1;
      end
    end

    echo_cnt_d = echo_cnt_q;
    cm_sub_d   = cm_sub_q;
    cm_cnt_d   = cm_cnt_q;
    if (state_q == StWaitRise) begin
      echo_cnt_d = '0;
      cm_sub_d   = '0;
      cm_cnt_d   = '0;
    end else if (state_q == StMeasure) begin
      echo_cnt_d = echo_inc;
      cm_sub_d   = cm_sub_inc;
      cm_cnt_d   = cm_inc;
    end

    echo_us_d  = echo_us_q;
    distance_d = distance_q;
    timeout_d  = timeout_q;
    if (load_valid) begin
      echo_us_d  = echo_inc;
      distance_d = cm_inc;
      timeout_d  = 1'b0;
    end else if (load_to) begin
      echo_us_d  = 16'hFFFF;
      distance_d = 16'hFFFF;
      timeout_d  = 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      presc_q    <= '0;
      us_cnt_q   <= '0;
      to_cnt_q   <= '0;
      echo_cnt_q <= '0;
      cm_sub_q   <= '0;
      cm_cnt_q   <= '0;
      trig_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      echo_us_q  <= '0;
      distance_q <= '0;
    end else begin
      presc_q    <= presc_d;
      us_cnt_q   <= us_cnt_d;
      to_cnt_q   <= to_cnt_d;
      echo_cnt_q <= echo_cnt_d;
      cm_sub_q   <= cm_sub_d;
      cm_cnt_q   <= cm_cnt_d;
      trig_q     <= trig_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      echo_us_q  <= echo_us_d;
      distance_q <= distance_d;
    end
  end

  assign trig        = trig_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign echo_us     = echo_us_q;
  assign distance_cm = distance_q;

endmodule

// File: tb/tb_ultrasonic_meas_ctrl.sv
// Bench for ultrasonic_meas_ctrl at a 2 MHz timebase (2 cycles/us) with shortened
// timeout/holdoff; directed table, auto-repeat, reset and random runs.
module tb_ultrasonic_meas_ctrl;

  localparam int CLK_HZ  = 2000000;
  localparam int DIV     = 2;
  localparam int TRIG_US = 10;
  localparam int TO_US   = 1300;
  localparam int HO_US   = 40;
  localparam int CM      = 58;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        auto_en = 1'b0;
  logic        echo = 1'b0;
  logic        trig, busy, done, timeout;
  logic [15:0] echo_us, distance_cm;

  int checks = 0;
  int errors = 0;

  ultrasonic_meas_ctrl #(
    .CLK_FREQ_HZ(CLK_HZ),
    .TRIG_US    (TRIG_US),
    .TIMEOUT_US (TO_US),
    .HOLDOFF_US (HO_US),
    .CM_DIV_US  (CM)
  ) dut (
    .ACLK       (clk),
    .ARESETN    (rst_n),
    .start      (start),
    .auto_en    (auto_en),
    .echo       (echo),
    .trig       (trig),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .echo_us    (echo_us),
    .distance_cm(distance_cm)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          dly_us;
    int          wc;
    bit          stuck;
    logic [15:0] exp_us;
    logic [15:0] exp_cm;
    bit          exp_to;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Echo edges reach the sequencer 3 cycles after the pin; the window closes at
  // cycle TO_US*DIV-1 after trig falls and a fall seen in that cycle still wins.
  function automatic void model(input int dly_us, input int wc, input bit stuck,
                                output logic [15:0] us, output logic [15:0] cm,
                                output bit to, output int done_idx);
    int k;
    k = dly_us * DIV;
    if (!stuck && wc > 0 && (k + wc + 3) <= (TO_US * DIV - 1)) begin
      us       = 16'(wc / DIV);
      cm       = 16'((wc / DIV) / CM);
      to       = 1'b0;
      done_idx = k + wc + 4;
    end else begin
      us       = 16'hFFFF;
      cm       = 16'hFFFF;
      to       = 1'b1;
      done_idx = TO_US * DIV;
    end
  endfunction

  task automatic run(input int dly_us, input int wc, input bit stuck, input bit use_auto,
                     input bit inject, input bit drop_auto, input logic [15:0] exp_us,
                     input logic [15:0] exp_cm, input bit exp_to, input int exp_idx);
    int n, idx, cnt, k;
    bit seen, extra, dup;
    k = dly_us * DIV;
    if (!use_auto) begin
      start = 1'b1;
      step();
      start = 1'b0;
      check("trig_on_start", 32'({trig, busy}), 32'h3);
    end else begin
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        step();
        if (trig) begin
          seen = 1'b1;
          break;
        end
      end
      check("auto_retrig", 32'(seen), 32'h1);
    end

    n = 1;
    extra = 1'b0;
    forever begin
      if (stuck && n == 5) echo = 1'b1;
      if (done) extra = 1'b1;
      step();
      if (!trig || n >= 4000) break;
      n++;
    end
    check("trig_width", n, TRIG_US * DIV);
    check("no_done_in_trig", 32'(extra), 32'h0);

    idx = 0;
    seen = 1'b0;
    extra = 1'b0;
    while (idx < 3 * TO_US * DIV) begin
      if (!stuck && wc > 0) begin
        if (idx == k) echo = 1'b1;
        if (idx == k + wc) echo = 1'b0;
      end
      start = inject && (idx == k + 10);
      if (drop_auto && idx == k + 20) auto_en = 1'b0;
      if (trig) extra = 1'b1;
      if (done) begin
        seen = 1'b1;
        break;
      end
      step();
      idx++;
    end
    start = 1'b0;
    echo  = 1'b0;
    check("done_seen", 32'(seen), 32'h1);
    check("done_cycle", idx, exp_idx);
    check("echo_us", echo_us, exp_us);
    check("distance_cm", distance_cm, exp_cm);
    check("timeout_flag", 32'(timeout), 32'(exp_to));

    cnt = 1;
    dup = 1'b0;
    forever begin
      start = inject && (cnt == 10);
      step();
      if (done) dup = 1'b1;
      if (trig) extra = 1'b1;
      if (!busy || cnt >= 10000) break;
      cnt++;
    end
    start = 1'b0;
    check("done_one_cycle", 32'(dup), 32'h0);
    check("no_extra_trig", 32'(extra), 32'h0);
    check("holdoff_len", cnt, HO_US * DIV);
    check("result_hold", distance_cm, exp_cm);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[9];
    logic [15:0] mu, mc;
    bit          mt, ext;
    int          midx, dly, wc, n;

    vecs[0] = '{100, 1160, 1'b0, 16'd580, 16'd10, 1'b0};
    vecs[1] = '{100, 114, 1'b0, 16'd57, 16'd0, 1'b0};
    vecs[2] = '{100, 116, 1'b0, 16'd58, 16'd1, 1'b0};
    vecs[3] = '{0, 0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1};
    vecs[4] = '{100, 2320, 1'b0, 16'd1160, 16'd20, 1'b0};
    vecs[5] = '{100, 2396, 1'b0, 16'd1198, 16'd20, 1'b0};
    vecs[6] = '{100, 2397, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1};
    vecs[7] = '{0, 0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1};
    vecs[8] = '{7, 3, 1'b0, 16'd1, 16'd0, 1'b0};

    step();
    step();
    check("rst_flags", 32'({trig, busy, done, timeout}), 32'h0);
    check("rst_results", {echo_us, distance_cm}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();

    foreach (vecs[i]) begin
      model(vecs[i].dly_us, vecs[i].wc, vecs[i].stuck, mu, mc, mt, midx);
      run(vecs[i].dly_us, vecs[i].wc, vecs[i].stuck, 1'b0, 1'b0, 1'b0,
          vecs[i].exp_us, vecs[i].exp_cm, vecs[i].exp_to, midx);
    end

    // Free-running mode with start pulses that must be dropped.
    auto_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      model(20, 580, 1'b0, mu, mc, mt, midx);
      run(20, 580, 1'b0, 1'b1, 1'b1, r == 2, 16'd290, 16'd5, 1'b0, midx);
    end
    ext = 1'b0;
    repeat (20) begin
      step();
      if (trig || busy) ext = 1'b1;
    end
    check("auto_stopped", 32'(ext), 32'h0);

    for (int r = 0; r < 8; r++) begin
      dly = int'($urandom_range(0, 200));
      wc  = int'($urandom_range(1, 2700));
      model(dly, wc, 1'b0, mu, mc, mt, midx);
      run(dly, wc, 1'b0, 1'b0, 1'b1, 1'b0, mu, mc, mt, midx);
    end

    // Asynchronous reset in the middle of the trigger pulse.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    check("rst_trig_flags", 32'({trig, busy, done, timeout}), 32'h0);
    check("rst_trig_results", {echo_us, distance_cm}, 32'h0);
    #3 rst_n = 1'b1;
    ext = 1'b0;
    repeat (30) begin
      step();
      if (trig || busy) ext = 1'b1;
    end
    check("idle_after_rst_trig", 32'(ext), 32'h0);

    // Asynchronous reset while an echo is being timed.
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (trig && n < 100) begin
      step();
      n++;
    end
    check("trig_fall_seen", 32'(trig), 32'h0);
    echo = 1'b1;
    repeat (200) step();
    check("busy_mid_meas", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_meas_flags", 32'({trig, busy, done, timeout}), 32'h0);
    echo = 1'b0;
    #3 rst_n = 1'b1;
    ext = 1'b0;
    repeat (30) begin
      step();
      if (trig || busy) ext = 1'b1;
    end
    check("idle_after_rst_meas", 32'(ext), 32'h0);

    model(10, 200, 1'b0, mu, mc, mt, midx);
    run(10, 200, 1'b0, 1'b0, 1'b0, 1'b0, 16'd100, 16'd1, 1'b0, midx);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
